// File: rtl/alu_mc.sv
// Multi-cycle handshaked PLC ALU: single-cycle logic/arith/compare ops plus
// iterative shift-add MUL and restoring DIV/MOD, with valid/ready on both sides.
module alu_mc #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] op_code,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              c_in,
  input  logic              b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              c_out,
  output logic              b_out,
  output logic              flag_valid,
  output logic              div_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  // Opcode map shared with the operand-select stage; anything else passes in_a.
  localparam logic [IWIDTH-1:0] OP_LD   = IWIDTH'('h00);
  localparam logic [IWIDTH-1:0] OP_LDN  = IWIDTH'('h01);
  localparam logic [IWIDTH-1:0] OP_ST   = IWIDTH'('h02);
  localparam logic [IWIDTH-1:0] OP_STN  = IWIDTH'('h03);
  localparam logic [IWIDTH-1:0] OP_S    = IWIDTH'('h04);
  localparam logic [IWIDTH-1:0] OP_R    = IWIDTH'('h05);
  localparam logic [IWIDTH-1:0] OP_AND  = IWIDTH'('h06);
  localparam logic [IWIDTH-1:0] OP_ANDN = IWIDTH'('h07);
  localparam logic [IWIDTH-1:0] OP_OR   = IWIDTH'('h08);
  localparam logic [IWIDTH-1:0] OP_ORN  = IWIDTH'('h09);
  localparam logic [IWIDTH-1:0] OP_XOR  = IWIDTH'('h0A);
  localparam logic [IWIDTH-1:0] OP_XORN = IWIDTH'('h0B);
  localparam logic [IWIDTH-1:0] OP_NOT  = IWIDTH'('h0C);
  localparam logic [IWIDTH-1:0] OP_ADD  = IWIDTH'('h0D);
  localparam logic [IWIDTH-1:0] OP_SUB  = IWIDTH'('h0E);
  localparam logic [IWIDTH-1:0] OP_MUL  = IWIDTH'('h0F);
  localparam logic [IWIDTH-1:0] OP_DIV  = IWIDTH'('h10);
  localparam logic [IWIDTH-1:0] OP_MOD  = IWIDTH'('h11);
  localparam logic [IWIDTH-1:0] OP_GT   = IWIDTH'('h12);
  localparam logic [IWIDTH-1:0] OP_GE   = IWIDTH'('h13);
  localparam logic [IWIDTH-1:0] OP_EQ   = IWIDTH'('h14);
  localparam logic [IWIDTH-1:0] OP_NE   = IWIDTH'('h15);
  localparam logic [IWIDTH-1:0] OP_LE   = IWIDTH'('h16);
  localparam logic [IWIDTH-1:0] OP_LT   = IWIDTH'('h17);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;       // multiplicand or divisor
  logic [WIDTH-1:0]   r_hi;      // product high half or partial remainder
  logic [WIDTH-1:0]   r_lo;      // multiplier -> product low half, or dividend -> quotient
  logic               r_is_mul;
  logic               r_is_mod;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_c_out, r_b_out, r_flag_valid, r_div_err;

  logic               w_accept, w_is_div, w_b_zero, w_a_zero, w_iter;
  logic [WIDTH:0]     w_sum, w_diff, w_mul_sum, w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_b, w_fv, w_derr;

  assign in_ready   = (r_state == S_IDLE) & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & in_ready;
  assign w_is_div   = (op_code == OP_DIV) | (op_code == OP_MOD);
  assign w_b_zero   = (in_b == '0);
  assign w_a_zero   = (in_a == '0);
  assign w_iter     = (op_code == OP_MUL) | (w_is_div & ~w_b_zero);

  assign w_sum      = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(c_in);
  assign w_diff     = {1'b0, in_a} - {1'b0, in_b} - (WIDTH+1)'(b_in);

  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_a});
  // Only used when the trial subtract succeeds, so the result always fits WIDTH bits.
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_a;

  assign busy       = (r_state == S_MUL) | (r_state == S_DIV);
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign c_out      = r_c_out;
  assign b_out      = r_b_out;
  assign flag_valid = r_flag_valid;
  assign div_err    = r_div_err;

  // Single-cycle result path; MUL and non-zero DIV/MOD are finished by the FSM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    w_res  = in_a;
    w_c    = 1'b0;
    w_b    = 1'b0;
    w_fv   = 1'b0;
    w_derr = 1'b0;
    case (op_code)
      OP_LD, OP_ST:   w_res = in_a;
      OP_LDN, OP_STN: w_res = ~in_a;
      OP_S:           w_res = '1;
      OP_R:           w_res = '0;
      OP_AND:         w_res = in_a & in_b;
      OP_ANDN:        w_res = in_a & ~in_b;
      OP_OR:          w_res = in_a | in_b;
      OP_ORN:         w_res = in_a | ~in_b;
      OP_XOR:         w_res = in_a ^ in_b;
      OP_XORN:        w_res = in_a ^ ~in_b;
      OP_NOT: begin
        w_res = WIDTH'(w_a_zero);
        w_b   = w_a_zero;
      end
      OP_ADD: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_fv  = 1'b1;
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_b   = w_diff[WIDTH];
        w_fv  = 1'b1;
      end
      OP_DIV: begin
        w_res  = '1;
        w_derr = 1'b1;
      end
      OP_MOD: begin
        w_res  = in_a;
        w_derr = 1'b1;
      end
      OP_GT:          w_res = {WIDTH{in_a >  in_b}};
      OP_GE:          w_res = {WIDTH{in_a >= in_b}};
      OP_EQ:          w_res = {WIDTH{in_a == in_b}};
      OP_NE:          w_res = {WIDTH{in_a != in_b}};
      OP_LE:          w_res = {WIDTH{in_a <= in_b}};
      OP_LT:          w_res = {WIDTH{in_a <  in_b}};
      default:        w_res = in_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_iter) w_next = (op_code == OP_MUL) ? S_MUL : S_DIV;
      S_MUL,
      S_DIV:  if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Iteration datapath: one multiplier/quotient bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, including the shift/counter datapath, is cleared by reset so an aborted op leaves no residue.
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_mul <= 1'b0;
      r_is_mod <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_accept && w_iter) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_hi     <= '0;
        r_is_mul <= (op_code == OP_MUL);
        r_is_mod <= (op_code == OP_MOD);
        if (op_code == OP_MUL) begin
          r_a  <= in_a;
          r_lo <= in_b;
        end else begin
          r_a  <= in_b;
          r_lo <= in_a;
        end
      end
    end else if (r_state == S_MUL) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= w_mul_sum[WIDTH:1];
      r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (r_state == S_DIV) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_hi  <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
    end
  end

  // Result registers hold until consumed; a same-edge single-cycle accept reloads them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_result     <= '0;
      r_c_out      <= 1'b0;
      r_b_out      <= 1'b0;
      r_flag_valid <= 1'b0;
      r_div_err    <= 1'b0;
    end else if (w_accept && !w_iter) begin
      r_out_valid  <= 1'b1;
      r_result     <= w_res;
      r_c_out      <= w_c;
      r_b_out      <= w_b;
      r_flag_valid <= w_fv;
      r_div_err    <= w_derr;
    end else if (r_state == S_DONE) begin
      r_out_valid  <= 1'b1;
      r_result     <= (r_is_mod && !r_is_mul) ? r_hi : r_lo;
      r_c_out      <= r_is_mul & (|r_hi);
      r_b_out      <= 1'b0;
      r_flag_valid <= r_is_mul;
      r_div_err    <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: single-cycle ops, iterative MUL/DIV/MOD timing,
// backpressure and asynchronous reset abort.
module tb_alu_mc;

  localparam logic [7:0] OP_LD   = 8'h00, OP_LDN = 8'h01, OP_ST  = 8'h02, OP_STN = 8'h03;
  localparam logic [7:0] OP_S    = 8'h04, OP_R   = 8'h05, OP_AND = 8'h06, OP_ANDN = 8'h07;
  localparam logic [7:0] OP_OR   = 8'h08, OP_ORN = 8'h09, OP_XOR = 8'h0A, OP_XORN = 8'h0B;
  localparam logic [7:0] OP_NOT  = 8'h0C, OP_ADD = 8'h0D, OP_SUB = 8'h0E, OP_MUL = 8'h0F;
  localparam logic [7:0] OP_DIV  = 8'h10, OP_MOD = 8'h11, OP_GT  = 8'h12, OP_GE  = 8'h13;
  localparam logic [7:0] OP_EQ   = 8'h14, OP_NE  = 8'h15, OP_LE  = 8'h16, OP_LT  = 8'h17;

  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] op_code, in_a, in_b, result;
  logic       c_in, b_in, c_out, b_out, flag_valid, div_err, busy;

  int n_pass  = 0;
  int n_total = 0;

  // {out_valid, result, c_out, b_out, flag_valid, div_err}
  wire [12:0] obs = {out_valid, result, c_out, b_out, flag_valid, div_err};

  alu_mc #(.WIDTH(8), .IWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .in_a(in_a), .in_b(in_b), .c_in(c_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .b_out(b_out),
    .flag_valid(flag_valid), .div_err(div_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic bi, input logic v);
    op_code  = op;
    in_a     = a;
    in_b     = b;
    c_in     = ci;
    b_in     = bi;
    in_valid = v;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if ({obs, busy, in_ready} !== {13'h0, 1'b0, 1'b1})
      $display("FAIL reset_state: got %b want %b", {obs, busy, in_ready}, {13'h0, 1'b0, 1'b1});
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add_sub();
    out_ready = 1'b1;
    drive(OP_ADD, 8'hF0, 8'h20, 1'b1, 1'b0, 1'b1);
    tick();
    drive(OP_SUB, 8'h05, 8'h07, 1'b0, 1'b0, 1'b1);
    n_total++;
    if ({obs, in_ready} !== {1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1})
      $display("FAIL add_carry: got %h want %h", {obs, in_ready}, {1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (obs !== {1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0})
      $display("FAIL sub_borrow: got %h want %h", obs, {1'b1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL add_sub_drain: got out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  // Launches one iterative op and checks busy/in_ready timing plus the final result.
  task automatic iter_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input logic exp_c, input logic exp_fv,
                         input string name);
    out_ready = 1'b1;
    drive(op, a, b, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if ({busy, in_ready, out_valid} !== 3'b100)
        $display("FAIL %s_busy_%0d: got busy/in_ready/out_valid=%b want 100", name, i, {busy, in_ready, out_valid});
      else n_pass++;
      tick();
    end
    n_total++;
    if ({busy, in_ready, out_valid} !== 3'b000)
      $display("FAIL %s_done_cycle: got busy/in_ready/out_valid=%b want 000", name, {busy, in_ready, out_valid});
    else n_pass++;
    tick();
    n_total++;
    if (obs !== {1'b1, exp_res, exp_c, 1'b0, exp_fv, 1'b0})
      $display("FAIL %s_result: got %h want %h", name, obs, {1'b1, exp_res, exp_c, 1'b0, exp_fv, 1'b0});
    else n_pass++;
    tick();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL %s_drain: got out_valid=%b want 0", name, out_valid);
    else n_pass++;
  endtask

  task automatic test_mul();
    iter_op(OP_MUL, 8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b1, "mul_small");
    iter_op(OP_MUL, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1, "mul_ovf");
  endtask

  task automatic test_div();
    iter_op(OP_DIV, 8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, "div");
    iter_op(OP_MOD, 8'hC8, 8'h07, 8'h04, 1'b0, 1'b0, "mod");
    iter_op(OP_DIV, 8'h07, 8'hC8, 8'h00, 1'b0, 1'b0, "div_small");
    drive(OP_DIV, 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    drive(OP_MOD, 8'h42, 8'h00, 1'b0, 1'b0, 1'b1);
    n_total++;
    if (obs !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL div_by_zero: got %h want %h", obs, {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1});
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (obs !== {1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL mod_by_zero: got %h want %h", obs, {1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1});
    else n_pass++;
    tick();
  endtask

  task automatic test_logic();
    logic [7:0] ops  [20] = '{OP_EQ, OP_NE, OP_NOT, OP_NOT, 8'h7F, OP_AND, OP_ANDN, OP_OR, OP_ORN, OP_XOR,
                              OP_XORN, OP_GT, OP_LT, OP_GE, OP_LE, OP_S, OP_R, OP_LD, OP_LDN, OP_STN};
    logic [7:0] as   [20] = '{8'h3C, 8'h3C, 8'h00, 8'h05, 8'h5A, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                              8'hA5, 8'h10, 8'h10, 8'h20, 8'h21, 8'h12, 8'h12, 8'h3C, 8'h3C, 8'h3C};
    logic [7:0] bs   [20] = '{8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
                              8'h0F, 8'h20, 8'h20, 8'h20, 8'h20, 8'h34, 8'h34, 8'h00, 8'h00, 8'h00};
    logic [7:0] exps [20] = '{8'hFF, 8'h00, 8'h01, 8'h00, 8'h5A, 8'h05, 8'hA0, 8'hAF, 8'hF5, 8'hAA,
                              8'h55, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'hC3};
    logic       expb [20] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(ops[i], as[i], bs[i], 1'b1, 1'b1, 1'b1);
      tick();
      n_total++;
      if (obs !== {1'b1, exps[i], 1'b0, expb[i], 1'b0, 1'b0})
        $display("FAIL logic_op_%h: got %h want %h", ops[i], obs, {1'b1, exps[i], 1'b0, expb[i], 1'b0, 1'b0});
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(OP_ADD, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
    tick();
    drive(OP_SUB, 8'h44, 8'h11, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if ({obs, in_ready} !== {1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})
        $display("FAIL stall_hold_%0d: got %h want %h", i, {obs, in_ready}, {1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
      else n_pass++;
      tick();
    end
    drive(OP_SUB, 8'h09, 8'h04, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    n_total++;
    if (obs !== {1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL stall_next_op: got %h want %h", obs, {1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0});
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    out_ready = 1'b1;
    drive(OP_ADD, 8'h30, 8'h07, 1'b0, 1'b0, 1'b1);
    tick();
    drive(OP_MUL, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_mul_busy: got %b want 1", busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({obs, busy} !== 14'h0) $display("FAIL async_reset_clear: got %h want 0", {obs, busy});
    else n_pass++;
    #3 rst_n = 1'b1;
    tick();
    n_total++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL post_reset_idle: got in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) stale++;
      tick();
    end
    n_total++;
    if (stale !== 0) $display("FAIL no_stale_result: got %0d bad cycles want 0", stale);
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_logic();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, handshaked successor to the combinational PLC ALU.
- Executes the same IL opcode set (logic, arithmetic, compare, set/reset, load/store) on WIDTH-bit operands.
- MUL, DIV and MOD are iterative, so multiplier and divider cost no longer scales as WIDTH² combinational logic.
- Sits between the operand-select stage (source muxing is done upstream) and the register-file / bit-memory writeback, with valid/ready on both sides.

Parameters:
- WIDTH, 8, operand and result width (≥2).
- IWIDTH, 8, opcode width.
- CNT_W, $clog2(WIDTH+1), iteration-counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  ALU can accept a request this cycle.
- op_code  in  IWIDTH  opcode, sampled on accept.
- in_a  in  WIDTH  operand A, sampled on accept.
- in_b  in  WIDTH  operand B, sampled on accept.
- c_in  in  1  carry in (ADD).
- b_in  in  1  borrow in (SUB).
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  operation result.
- c_out  out  1  carry out (ADD); overflow (MUL).
- b_out  out  1  borrow out (SUB); boolean result (NOT).
- flag_valid  out  1  c_out/b_out are meaningful (ADD, SUB, MUL).
- div_err  out  1  DIV/MOD with in_b == 0.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=IDLE; out_valid=0; result=0; c_out=0; b_out=0; flag_valid=0; div_err=0; busy=0.
  - Internal: counter and shift registers cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- Accept: in_valid & in_ready at a rising edge. in_ready = (state==IDLE) & (~out_valid | out_ready).
- Output hold: the result, all flags and out_valid hold stable until out_valid & out_ready. They clear to out_valid=0 at that edge unless a new single-cycle op is accepted at the same edge, in which case the new result loads.
- States:
  - IDLE: on accept of a single-cycle op, register the result, out_valid=1 next cycle (latency 1, throughput 1/cycle).
    - MUL goes to MUL.
    - DIV/MOD with in_b≠0 goes to DIV.
    - DIV/MOD with in_b==0: latency 1, div_err=1; result = all-ones (DIV) or in_a (MOD).
  - MUL: shift-add, one multiplier bit per cycle, WIDTH cycles, busy=1. Then DONE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles, busy=1. Then DONE.
  - DONE: one cycle. Load result, out_valid=1, go to IDLE.
  - Total latency accept→out_valid for MUL/DIV/MOD = WIDTH+1 cycles. in_ready=0 throughout.
- Arithmetic, all unsigned:
  - ADD: {c_out,result} = a+b+c_in; flag_valid=1.
  - SUB: {b_out,result} = a−b−b_in (WIDTH+1-bit); flag_valid=1.
  - MUL: result = low WIDTH bits; c_out = OR of high WIDTH bits; flag_valid=1.
  - DIV: result = quotient. MOD: result = remainder.
- Logic:
  - AND/ANDN/OR/ORN/XOR/XORN: bitwise, with ~in_b for the N forms.
  - NOT: result = b_out = (in_a==0); result zero-extended.
- Compare, GT/GE/EQ/NE/LE/LT: result = all-ones if true, else all-zero. EQ/NE use the same all-ones/zero encoding as the other compares.
- Set/reset/load/store: S = all-ones; R = 0; ST/LD = in_a; STN/LDN = ~in_a.
- Unlisted opcodes: result = in_a, latency 1.
- c_out, b_out, div_err = 0 for every op not listed above as setting them. flag_valid = 0 for every op except ADD/SUB/MUL.
- Input handling: in_valid while in_ready=0 is ignored; inputs are not captured.

Test Plan:
- ADD a=8'hF0, b=8'h20, c_in=1 → next cycle result=8'h11, c_out=1, flag_valid=1, out_valid=1. Back-to-back SUB a=8'h05, b=8'h07, b_in=0 on the following cycle → result=8'hFE, b_out=1.
- MUL a=8'h0D, b=8'h0B → in_ready=0 and busy=1 for 8 cycles; out_valid exactly 9 cycles after accept; result=8'h8F, c_out=0. MUL a=8'h20, b=8'h10 → result=8'h00, c_out=1.
- DIV a=8'hC8, b=8'h07 → result=8'h1C after 9 cycles. MOD with same operands → 8'h04. DIV with b=0 → result=8'hFF, div_err=1, latency 1.
- Compare/logic sweep: EQ 8'h3C,8'h3C → 8'hFF; NE same operands → 8'h00; NOT a=0 → result=8'h01, b_out=1; opcode 8'h7F a=8'h5A → 8'h5A.
- Backpressure: hold out_ready=0 for 3 cycles after an ADD result → result and flags stable, in_ready=0, new in_valid ignored. Raise out_ready → in_ready=1 in the same cycle.
- Assert rst_n=0 asynchronously during cycle 4 of a MUL → out_valid, busy, result cleared immediately. After release, in_ready=1 and no stale result appears.
